// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Definitions shared by the UART transmit and receive paths:
//                frame FSM state encoding, parity-mode constants and the
//                bit-period helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Frame FSM states, explicitly 3 bits wide
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    localparam int PARITY_EVEN = 0;
    localparam int PARITY_ODD  = 1;

    // Bit period in clk cycles: 2*(ticks+1), kept modulo 2^33. For
    // ticks = 2^32-1 the result wraps to 0, but (result - 1) taken in the
    // same 33-bit width is still the correct terminal count 2^33-1.
    function automatic logic [32:0] bit_period(input logic [31:0] ticks);
        return {ticks, 1'b0} + 33'd2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ============================================================================
//  Module      : uart_baud_gen
//  Description : Bit-period timer. Counts 0 .. P-1 with P = 2*(ticks+1) and
//                flags the last cycle of each bit period.
//  Ports       : clk, reset    - clock, asynchronous active-high reset
//                i_clear       - restart the count at 0 (frame accept)
//                i_enable      - count while a frame is on the line
//                i_ticks       - latched baud setting
//                o_bit_end     - one-cycle pulse on the last cycle of a bit
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_baud_gen
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        i_clear,
    input  logic        i_enable,
    input  logic [31:0] i_ticks,
    output logic        o_bit_end
);

    logic [32:0] r_cnt;
    logic [32:0] w_term;

    assign w_term    = bit_period(i_ticks) - 33'd1;
    assign o_bit_end = i_enable && (r_cnt == w_term);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_enable) begin
            if (o_bit_end) r_cnt <= '0;
            else           r_cnt <= r_cnt + 33'd1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_frame
//  Description : UART frame transmitter. Accepts a word on a valid/ready
//                handshake and sends start bit, DATA_BITS data bits LSB
//                first, optional parity bit and SB_TICKS stop bits.
//  Ports       : clk, reset    - clock, asynchronous active-high reset
//                ticks_per_bit - baud setting, bit = 2*(ticks_per_bit+1) clks
//                tx_start      - word on tx_data_in is valid
//                tx_data_in    - word to send
//                tx_ready      - a word can be accepted (FSM idle)
//                tx_busy       - frame in progress
//                tx_done       - one-cycle pulse when the frame completes
//                tx            - serial line, idle high
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS = 8,
    parameter int SB_TICKS  = 2,
    parameter int IS_PARITY = 1,
    parameter int PARITY    = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          ticks_per_bit,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] tx_data_in,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int c_IDX_W = $clog2(DATA_BITS);

    state_t               r_state;
    logic [DATA_BITS-1:0] r_shreg;
    logic [c_IDX_W-1:0]   r_bit_idx;
    logic                 r_stop_cnt;
    logic                 r_parity;
    logic [31:0]          r_ticks;
    logic                 r_tx;
    logic                 r_done;
    logic                 w_accept;
    logic                 w_bit_end;
    logic                 w_parity;

    assign tx_ready = (r_state == ST_IDLE);
    assign tx_busy  = !tx_ready;
    assign tx_done  = r_done;
    assign tx       = r_tx;
    assign w_accept = tx_start && tx_ready;
    assign w_parity = (^tx_data_in) ^ (PARITY == PARITY_ODD);

    uart_baud_gen u_baud (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_accept),
        .i_enable  (tx_busy),
        .i_ticks   (r_ticks),
        .o_bit_end (w_bit_end)
    );

    // The shift register is consumed from bit 0; each bit period end moves
    // the next data bit onto the line and shifts the rest down.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_stop_cnt <= 1'b0;
            r_parity   <= 1'b0;
            r_ticks    <= '0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (tx_start) begin
                        r_shreg  <= tx_data_in;
                        r_ticks  <= ticks_per_bit;
                        r_parity <= w_parity;
                        r_tx     <= 1'b0;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    if (w_bit_end) begin
                        r_tx      <= r_shreg[0];
                        r_shreg   <= r_shreg >> 1;
                        r_bit_idx <= '0;
                        r_state   <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (w_bit_end) begin
                        if (r_bit_idx == c_IDX_W'(DATA_BITS - 1)) begin
                            r_stop_cnt <= 1'b0;
                            if (IS_PARITY != 0) begin
                                r_tx    <= r_parity;
                                r_state <= ST_PARITY;
                            end else begin
                                r_tx    <= 1'b1;
                                r_state <= ST_STOP;
                            end
                        end else begin
                            r_tx      <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_tx    <= 1'b1;
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt == 1'(SB_TICKS - 1)) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_stop_cnt <= r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx_frame
//  Description : Self-checking bench for uart_tx_frame. Three instances cover
//                even parity / 2 stop, odd parity / 2 stop and no parity /
//                1 stop. Expected line values come from a per-frame bit list
//                built from the frame rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_frame;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] ticks = 32'd0;
    logic [2:0]  tx_start = 3'b000;
    logic [7:0]  tx_data [3];
    logic [2:0]  tx_ready, tx_busy, tx_done, tx;

    int checks = 0;
    int errors = 0;

    // Per-instance frame parameters
    int c_SB  [3] = '{2, 2, 1};
    int c_ISP [3] = '{1, 1, 0};
    int c_PAR [3] = '{0, 1, 0};

    always #5 clk = ~clk;

    uart_tx_frame #(.DATA_BITS(8), .SB_TICKS(2), .IS_PARITY(1), .PARITY(0)) u_dut0 (
        .clk(clk), .reset(reset), .ticks_per_bit(ticks), .tx_start(tx_start[0]),
        .tx_data_in(tx_data[0]), .tx_ready(tx_ready[0]), .tx_busy(tx_busy[0]),
        .tx_done(tx_done[0]), .tx(tx[0]));

    uart_tx_frame #(.DATA_BITS(8), .SB_TICKS(2), .IS_PARITY(1), .PARITY(1)) u_dut1 (
        .clk(clk), .reset(reset), .ticks_per_bit(ticks), .tx_start(tx_start[1]),
        .tx_data_in(tx_data[1]), .tx_ready(tx_ready[1]), .tx_busy(tx_busy[1]),
        .tx_done(tx_done[1]), .tx(tx[1]));

    uart_tx_frame #(.DATA_BITS(8), .SB_TICKS(1), .IS_PARITY(0), .PARITY(0)) u_dut2 (
        .clk(clk), .reset(reset), .ticks_per_bit(ticks), .tx_start(tx_start[2]),
        .tx_data_in(tx_data[2]), .tx_ready(tx_ready[2]), .tx_busy(tx_busy[2]),
        .tx_done(tx_done[2]), .tx(tx[2]));

    // Offer a word at a falling edge; the next rising edge is the accept edge.
    task automatic start_frame(input int idx, input logic [7:0] data, input int tk);
        @(negedge clk);
        checks++;
        if (tx_ready[idx] !== 1'b1) begin
            errors++;
            $display("FAIL ready_before_start dut%0d: got %b want 1", idx, tx_ready[idx]);
        end
        ticks         = tk;
        tx_data[idx]  = data;
        tx_start[idx] = 1'b1;
        @(posedge clk);
    endtask

    // Called right after an accept edge. Checks every cycle of the frame plus
    // the completion cycle. hold_next keeps tx_start high with next_data so
    // the completion edge accepts another word; otherwise tx_start is toggled
    // randomly while busy and dropped on the completion cycle.
    task automatic check_frame(input int idx, input logic [7:0] data, input int p,
                               input bit hold_next, input logic [7:0] next_data,
                               input int new_ticks);
        logic bits[$];
        int   total;
        logic exp_tx, exp_done;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(data[i]);
        if (c_ISP[idx] != 0) bits.push_back((^data) ^ c_PAR[idx][0]);
        for (int i = 0; i < c_SB[idx]; i++) bits.push_back(1'b1);
        total = bits.size() * p;
        for (int k = 0; k <= total; k++) begin
            @(negedge clk);
            exp_tx   = (k < total) ? bits[k / p] : 1'b1;
            exp_done = (k == total);
            checks++;
            if (tx[idx] !== exp_tx || tx_done[idx] !== exp_done ||
                tx_ready[idx] !== exp_done || tx_busy[idx] !== !exp_done) begin
                errors++;
                $display("FAIL frame dut%0d data=%h cycle %0d: tx/done/ready/busy got %b%b%b%b want %b%b%b%b",
                         idx, data, k, tx[idx], tx_done[idx], tx_ready[idx], tx_busy[idx],
                         exp_tx, exp_done, exp_done, !exp_done);
            end
            if (k == 0 && new_ticks >= 0) ticks = new_ticks;
            if (hold_next) begin
                tx_start[idx] = 1'b1;
                tx_data[idx]  = next_data;
            end else begin
                tx_start[idx] = (k < total) ? 1'($urandom_range(1)) : 1'b0;
                tx_data[idx]  = 8'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (tx[i] !== 1'b1 || tx_ready[i] !== 1'b1 || tx_busy[i] !== 1'b0 || tx_done[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_values dut%0d: tx/ready/busy/done got %b%b%b%b want 1100",
                         i, tx[i], tx_ready[i], tx_busy[i], tx_done[i]);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_defaults();
        start_frame(0, 8'hB4, 2);
        check_frame(0, 8'hB4, 6, 1'b0, 8'h00, -1);
    endtask

    task automatic test_odd_parity();
        start_frame(1, 8'h9A, 2);
        check_frame(1, 8'h9A, 6, 1'b0, 8'h00, -1);
    endtask

    task automatic test_no_parity();
        start_frame(2, 8'hFF, 0);
        check_frame(2, 8'hFF, 2, 1'b0, 8'h00, -1);
    endtask

    task automatic test_back_to_back();
        start_frame(0, 8'h55, 1);
        check_frame(0, 8'h55, 4, 1'b1, 8'hAA, -1);
        // Completion edge of the first frame accepted 0xAA
        check_frame(0, 8'hAA, 4, 1'b0, 8'h00, -1);
    endtask

    task automatic test_ticks_change();
        start_frame(0, 8'hC3, 2);
        check_frame(0, 8'hC3, 6, 1'b0, 8'h00, 5);
        start_frame(0, 8'h3C, 5);
        check_frame(0, 8'h3C, 12, 1'b0, 8'h00, -1);
    endtask

    task automatic test_reset_mid_frame();
        start_frame(0, 8'hB4, 2);
        // Into data bit 3: start bit (6) + bits 0..2 (18) + 2 cycles
        repeat (6 * 4 + 3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || tx_busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: tx/ready/busy got %b%b%b want 110", tx[0], tx_ready[0], tx_busy[0]);
        end
        tx_start[0] = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (tx_done[0] !== 1'b0 || tx[0] !== 1'b1) begin
                errors++;
                $display("FAIL reset_no_done cycle %0d: done/tx got %b%b want 01", k, tx_done[0], tx[0]);
            end
        end
        reset = 1'b0;
        start_frame(0, 8'hB4, 2);
        check_frame(0, 8'hB4, 6, 1'b0, 8'h00, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 8; n++) begin
            int          idx;
            int          tk;
            logic [7:0]  d;
            idx = int'($urandom_range(2));
            tk  = int'($urandom_range(3));
            d   = 8'($urandom);
            start_frame(idx, d, tk);
            check_frame(idx, d, 2 * (tk + 1), 1'b0, 8'h00, int'($urandom_range(3)));
        end
    endtask

    initial begin
        for (int i = 0; i < 3; i++) tx_data[i] = 8'h00;
        test_reset();
        test_defaults();
        test_odd_parity();
        test_no_parity();
        test_back_to_back();
        test_ticks_change();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
